// File: rtl/pipe_credit_fifo.sv
// rtl/pipe_credit_fifo.sv - credit-issuing result buffer behind a fixed-latency, non-stallable pipeline
// Optional status outputs (err, level) enabled by `define PIPE_CREDIT_FIFO_STATUS_EN.
module pipe_credit_fifo #(
    parameter int WIDTH   = 24,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     issue_ready,
    input  logic                     issue_valid,
    input  logic                     pipe_valid,
    input  logic [WIDTH-1:0]         pipe_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("pipe_credit_fifo: LATENCY must be >= 1 and DEPTH a power of two >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    r_occ;

    logic [CW:0]      w_credit_sum;
    logic             w_iss;
    logic             w_wr;
    logic             w_rd;

    // Credits come from registered counts only, so a same-cycle pop never frees a slot early.
    assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_occ};
    assign issue_ready  = rst_n && (w_credit_sum < L_DEPTH);
    assign w_iss        = issue_valid && issue_ready;
    assign w_wr         = pipe_valid && (r_inflight != '0);
    assign out_valid    = rst_n && (r_occ != '0);
    assign w_rd         = out_valid && out_ready;
    assign out_data     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= '0;
            r_occ      <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_inflight <= r_inflight + CW'(w_iss) - CW'(w_wr);
            r_occ      <= r_occ + CW'(w_wr) - CW'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && rst_n) begin
            r_mem[r_wr_ptr] <= pipe_data;
        end
    end

`ifdef PIPE_CREDIT_FIFO_STATUS_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((issue_valid && !issue_ready) || (pipe_valid && r_inflight == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign err   = r_err;
    assign level = rst_n ? r_occ : '0;
`else
    assign err   = 1'b0;
    assign level = '0;
`endif

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// tb/tb_pipe_credit_fifo.sv - randomized and directed checks of pipe_credit_fifo against a queue model
module tb_pipe_credit_fifo;

    localparam int WIDTH = 24;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
`ifdef PIPE_CREDIT_FIFO_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic             pipe_valid = 1'b0;
    logic [WIDTH-1:0] pipe_data = '0;
    logic             out_ready = 1'b0;
    logic             issue_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       level;
    logic             err;

    pipe_credit_fifo #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: stored words as a queue, in-flight items as a plain count.
    logic [WIDTH-1:0] m_q [$];
    int               m_inflight = 0;
    bit               m_err = 1'b0;
    logic [WIDTH-1:0] next_tag = 24'h000001;
    bit               dl_v [LAT];
    logic [WIDTH-1:0] dl_d [LAT];
    int               acc_cnt = 0;

    task automatic cycle(input bit iv, input bit ordy, input bit rstv);
        bit m_ready;
        bit wr;
        bit rd;
        bit iss;
        rst_n       = rstv;
        issue_valid = iv;
        out_ready   = ordy;
        pipe_valid  = dl_v[LAT-1];
        pipe_data   = dl_d[LAT-1];
        m_ready     = rst_n && ((m_inflight + m_q.size()) < DEPTH);
        iss         = iv && m_ready;
        #1;
        if (iv && issue_ready) acc_cnt++;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_inflight = 0;
            m_err      = 1'b0;
        end else begin
            wr = pipe_valid && (m_inflight > 0);
            rd = ordy && (m_q.size() > 0);
            if ((iv && !m_ready) || (pipe_valid && m_inflight == 0)) m_err = 1'b1;
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(pipe_data);
            if (iss) m_inflight++;
            if (wr) m_inflight--;
        end
        for (int i = LAT - 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
        end
        dl_v[0] = iss;
        dl_d[0] = next_tag;
        if (iss) next_tag = next_tag + 24'h1;
        @(negedge clk);
        check_eq("issue_ready", 32'(issue_ready),
                 32'(rst_n && ((m_inflight + m_q.size()) < DEPTH)));
        check_eq("out_valid", 32'(out_valid), 32'(rst_n && m_q.size() != 0));
        if (m_q.size() != 0) check_eq("out_data", 32'(out_data), 32'(m_q[0]));
        check_eq("level", 32'(level), STATUS ? 32'(m_q.size()) : 32'd0);
        check_eq("err", 32'(err), STATUS ? 32'(m_err) : 32'd0);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < LAT; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end
        @(negedge clk);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_eq("rst_issue_ready", 32'(issue_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);

        // Streaming 0x000001..0x000010 back-to-back
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 1);
            if (i == 8) check_eq("stream_level", 32'(level), STATUS ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 8; i++) cycle(0, 1, 1);
        check_eq("stream_err", 32'(err), 32'd0);

        // Back-pressure: 12 cycles of issue_valid with out_ready low
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) cycle(1, 0, 1);
        check_eq("bp_accepted", 32'(acc_cnt), 32'd8);
        check_eq("bp_level", 32'(level), STATUS ? 32'd8 : 32'd0);
        cycle(0, 1, 1);
        check_eq("bp_credit_back", 32'(issue_ready), 32'd1);
        for (int i = 0; i < 10; i++) cycle(0, 1, 1);

        // Reset to clear err from the over-issue above, then capture+pop at occupancy 7
        cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        check_eq("full_level_pre", 32'(level), STATUS ? 32'd7 : 32'd0);
        cycle(0, 1, 1);
        check_eq("full_level_simul", 32'(level), STATUS ? 32'd7 : 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 1);

        // Reset with 3 items in flight
        for (int i = 0; i < 3; i++) cycle(1, 1, 1);
        cycle(0, 1, 0);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_level", 32'(level), 32'd0);
        check_eq("midrst_issue_ready", 32'(issue_ready), 32'd0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1);
        check_eq("midrst_drop_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_err", 32'(err), STATUS ? 32'd1 : 32'd0);

        // Credit violation
        cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1);
        cycle(1, 0, 1);
        check_eq("viol_err", 32'(err), STATUS ? 32'd1 : 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        check_eq("viol_level", 32'(level), STATUS ? 32'd8 : 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 1);
        check_eq("viol_err_sticky", 32'(err), STATUS ? 32'd1 : 32'd0);
        cycle(0, 0, 0);
        check_eq("viol_err_cleared", 32'(err), 32'd0);

        // Pointer wrap: 20 items, random issue and 50% out_ready
        acc_cnt = 0;
        guard   = 0;
        while (acc_cnt < 20 && guard < 400) begin
            cycle(1'($urandom % 2), 1'($urandom % 2), 1);
            guard++;
        end
        check_eq("wrap_issued", 32'(acc_cnt), 32'd20);
        for (int i = 0; i < 20; i++) cycle(0, 1'($urandom % 2), 1);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1);
        check_eq("wrap_drained", 32'(out_valid), 32'd0);
        check_eq("wrap_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
